// File: rtl/cpu_pkg.sv
// cpu_pkg: shared pipeline widths, fetch NOP and the fetch bundle carried from IF to ID
package cpu_pkg;
  localparam int PC_W = 32;
  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              adel;
  } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: register-based FIFO with flush and combinational head read
//   clk/rst : clock, synchronous active-high reset (clears storage too)
//   push_i/din_i : write din_i at the tail
//   pop_i   : advance the head
//   flush_i : empty the FIFO next cycle, overriding push/pop
//   count_o : occupancy, head_o : entry at the read pointer
module sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [W-1:0]               din_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [W-1:0]               head_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  assign count_o = cnt_q;
  assign head_o = mem_q[rd_q];
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= din_i;
        wr_q <= wr_q + 1'b1;
      end
      if (pop_i) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end
endmodule

// File: rtl/inst_fetch_buffer.sv
// inst_fetch_buffer: pairs IF requests with next-cycle SRAM data and queues them for ID
//   req_valid/req_pc : fetch issued by IF (dropped while stall_out is high)
//   inst_rdata       : SRAM data for the request of the previous cycle
//   flush            : discard everything queued and in flight
//   stall_out        : back-pressure to IF, from registered state only
//   id_valid/id_ready/id_pc/id_inst/id_adel : head entry handshake to ID
module inst_fetch_buffer
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [PC_W-1:0]   req_pc,
  input  logic [INST_W-1:0] inst_rdata,
  input  logic              flush,
  output logic              stall_out,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [PC_W-1:0]   id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              id_adel
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [CW-1:0] count;
  logic if_v_q, if_v_d, if_adel_q, if_adel_d;
  logic [PC_W-1:0] if_pc_q, if_pc_d;
  fetch_entry_t din, head;
  // an in-flight fetch is counted as occupied; a same-cycle pop is ignored on purpose
  assign stall_out = ({1'b0, count} + (CW + 1)'(if_v_q)) >= (CW + 1)'(DEPTH);
  assign id_valid = count != '0;
  assign id_pc = head.pc;
  assign id_inst = head.inst;
  assign id_adel = head.adel;
  assign din = '{pc: if_pc_q, inst: if_adel_q ? NOP_INST : inst_rdata, adel: if_adel_q};
  always_comb begin
    if_v_d = req_valid && !stall_out && !flush;
    if_pc_d = if_v_d ? req_pc : if_pc_q;
    if_adel_d = if_v_d ? (req_pc[1:0] != 2'b00) : if_adel_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      if_v_q <= 1'b0;
      if_pc_q <= '0;
      if_adel_q <= 1'b0;
    end else begin
      if_v_q <= if_v_d;
      if_pc_q <= if_pc_d;
      if_adel_q <= if_adel_d;
    end
  end
  sync_fifo #(.W($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (if_v_q),
    .din_i   (din),
    .pop_i   (id_valid && id_ready),
    .flush_i (flush),
    .count_o (count),
    .head_o  (head)
  );
endmodule

// File: tb/tb_inst_fetch_buffer.sv
// tb_inst_fetch_buffer: scoreboard bench with directed scenarios and random traffic
module tb_inst_fetch_buffer;
  import cpu_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b1, req_valid = 1'b0, flush = 1'b0, id_ready = 1'b0;
  logic [31:0] req_pc = '0, inst_rdata = '0;
  logic stall_out, id_valid, id_adel;
  logic [31:0] id_pc, id_inst;
  int total = 0, bad = 0;
  fetch_entry_t sb [$];
  int pend = 0;
  logic [31:0] nxt_rd = '0;

  always #5 clk = ~clk;

  inst_fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_pc(req_pc),
    .inst_rdata(inst_rdata), .flush(flush), .stall_out(stall_out),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_inst(id_inst), .id_adel(id_adel)
  );

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: each accepted head (handshake on the coming edge) must match the oldest expectation.
  always @(negedge clk) begin
    if (id_valid === 1'b1 && id_ready && !flush && !rst) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_entry at %0t: got pc=%h inst=%h expected none", $time, id_pc, id_inst);
      end else begin
        fetch_entry_t e;
        e = sb.pop_front();
        chk("entry", {id_pc, id_inst, id_adel}, e);
      end
    end
  end

  // One cycle of stimulus. Model: sb holds every accepted, unconsumed fetch (queued or in
  // flight); pend says whether the youngest one is still in flight.
  task automatic step(input bit r, input bit f, input bit rv, input logic [31:0] pc,
                      input logic [31:0] rd, input bit rdy);
    bit acc;
    chk("stall_out", {64'd0, stall_out}, {64'd0, sb.size() >= DEPTH});
    chk("id_valid", {64'd0, id_valid}, {64'd0, (sb.size() - pend) > 0});
    acc = rv && sb.size() < DEPTH && !f && !r;
    rst = r;
    flush = f;
    id_ready = rdy && !f && !r;
    inst_rdata = nxt_rd;
    req_valid = rv;
    req_pc = pc;
    if (r || f) sb.delete();
    if (acc) sb.push_back('{pc: pc, inst: (pc[1:0] != 2'b00) ? NOP_INST : rd, adel: pc[1:0] != 2'b00});
    pend = acc ? 1 : 0;
    nxt_rd = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_valid"}, {64'd0, id_valid}, 65'd0);
    chk({name, "_stall"}, {64'd0, stall_out}, 65'd0);
    chk({name, "_head"}, {id_pc, id_inst, id_adel}, 65'd0);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 32'h0, rdy);
  endtask

  initial begin
    @(posedge clk);
    #1;
    step(1, 0, 0, 0, 0, 0);
    chk_zero("reset");
    step(0, 0, 1, 32'h0, 32'h2000_0000, 1);
    step(0, 0, 1, 32'h4, 32'h2021_0001, 1);
    step(0, 0, 1, 32'h8, 32'h2042_0002, 1);
    idle(4, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 32'(i * 4), 32'hA000_0000 + 32'(i), 0);
    chk("full_entries", 65'(sb.size()), 65'd4);
    idle(6, 1);
    step(0, 0, 1, 32'h40, 32'h1, 0);
    step(0, 0, 1, 32'h44, 32'h2, 0);
    step(0, 0, 1, 32'h48, 32'h3, 0);
    step(0, 1, 1, 32'h4C, 32'h4, 1);
    chk("flush_valid", {64'd0, id_valid}, 65'd0);
    chk("flush_stall", {64'd0, stall_out}, 65'd0);
    step(0, 0, 1, 32'h100, 32'h1234_5678, 1);
    idle(4, 1);
    step(0, 0, 1, 32'h6, 32'hFFFF_FFFF, 0);
    idle(1, 0);
    chk("adel_head", {id_pc, id_inst, id_adel}, {32'h6, 32'h0, 1'b1});
    idle(2, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 32'h200 + 32'(i * 4), 32'hB0 + 32'(i), 0);
    for (int i = 3; i < 15; i++) step(0, 0, 1, 32'h200 + 32'(i * 4), 32'hB0 + 32'(i), 1);
    idle(6, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 32'h300 + 32'(i * 4), 32'hC0 + 32'(i), 0);
    step(1, 1, 1, 32'h400, 32'hD0, 1);
    chk_zero("rst_flush");
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] pc;
      pc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) pc = pc | 32'($urandom_range(1, 3));
      step($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 8,
           pc, $urandom, $urandom_range(0, 9) < 7);
    end
    idle(8, 1);
    chk("drained", 65'(sb.size()), 65'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
